// File: rtl/a0_uart_pkg.sv
// Shared types and constants for the a0 UART trace transmitter.
package a0_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         FRAME_BYTES       = 5;
endpackage

// File: rtl/a0_fifo.sv
// Synchronous FIFO for captured a0 values; push+pop in one cycle is accepted even when full.
module a0_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full, w_push_ok;

  assign w_full    = (r_count == CW'(DEPTH));
  // A pop frees the slot this same cycle, so a push into a full FIFO still lands.
  assign w_push_ok = push && (!w_full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (pop)       r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= din;
  end

  assign dout  = r_mem[r_rptr];
  assign empty = (r_count == '0);
  assign drop  = push && !w_push_ok;
  assign count = r_count;
endmodule

// File: rtl/a0_uart_tx.sv
// Captures changing a0 values and streams each as a 5-byte 8N1 UART frame (sync byte, then a0 LSB first).
module a0_uart_tx
  import a0_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 a0_i,
  input  logic                        en_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic                        overflow_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);
  localparam int            TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);
  localparam int            FW    = 8 * FRAME_BYTES;

  tx_state_t      r_state, w_state_nxt;
  logic [TW-1:0]  r_tcnt, w_tcnt_nxt;
  logic [2:0]     r_bit, w_bit_nxt, r_byte, w_byte_nxt;
  logic [FW-1:0]  r_frame, w_frame_nxt;
  logic           r_tx, w_tx_nxt, r_busy, w_busy_nxt;
  logic [31:0]    r_last;
  logic           r_ovf;
  logic           w_push, w_pop, w_empty, w_drop, w_bit_end;
  logic [31:0]    w_fifo_dout;

  // Only changes are traced; last value tracks a0 whenever capture is enabled.
  assign w_push    = en_i && (a0_i != r_last);
  assign w_bit_end = (r_tcnt == T_MAX);

  a0_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (a0_i),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .empty (w_empty),
    .drop  (w_drop),
    .count (fifo_count_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (en_i)   r_last <= a0_i;
      if (w_drop) r_ovf  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_frame <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_frame <= w_frame_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // The frame shifts right one bit per data bit, so the live bit is always r_frame[0].
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_frame_nxt = r_frame;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_frame_nxt = {w_fifo_dout, SYNC_BYTE};
          w_byte_nxt  = '0;
          w_tcnt_nxt  = '0;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_tcnt_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_frame[0];
          w_state_nxt = DATA;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_tcnt_nxt  = '0;
          w_frame_nxt = {1'b0, r_frame[FW-1:1]};
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = r_frame[1];
          end
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_tcnt_nxt = '0;
          if (r_byte < 3'(FRAME_BYTES - 1)) begin
            w_byte_nxt  = r_byte + 3'd1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = START;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign tx_o       = r_tx;
  assign busy_o     = r_busy;
  assign overflow_o = r_ovf;
endmodule
